// File: rtl/prores_buf_pkg.sv
// Shared types, defaults and block addressing for the coefficient ping-pong buffer.
// Latency: not applicable (package only).
// Backpressure: not applicable. Optional build macro: TRANSPOSE_EN (column-major block storage).
package prores_buf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_BLK_N        = 8;
    localparam int DEF_DEPTH_BLOCKS = 32;

    // Word address of coefficient (row, col) of block blk inside one bank.
    // The transposed layout keeps each column contiguous for vertical-scan coders.
    function automatic int unsigned blk_word_addr(
        input int unsigned blk,
        input int unsigned row,
        input int unsigned col,
        input int unsigned blk_n
    );
`ifdef TRANSPOSE_EN
        return blk * blk_n * blk_n + col * blk_n + row;
`else
        return blk * blk_n * blk_n + row * blk_n + col;
`endif
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One bank of block storage: whole-block write port, word-wide read port.
// Latency: write lands on the accept edge; read data is registered, one cycle after rd_en.
// Backpressure: none; the bank always accepts what the top level hands it. Honours TRANSPOSE_EN via blk_word_addr.
module pingpong_bank
    import prores_buf_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BLK_N        = DEF_BLK_N,
    parameter int DEPTH_BLOCKS = DEF_DEPTH_BLOCKS,
    localparam int BLK_WORDS   = BLK_N * BLK_N,
    localparam int BANK_WORDS  = DEPTH_BLOCKS * BLK_WORDS,
    localparam int AW          = $clog2(BANK_WORDS),
    localparam int CW          = $clog2(DEPTH_BLOCKS + 1)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     wr_en,
    input  logic [CW-1:0]                            wr_blk,
    input  logic [BLK_N-1:0][BLK_N-1:0][DATA_W-1:0]  wr_block,
    input  logic                                     rd_en,
    input  logic [AW-1:0]                            rd_addr,
    output logic [DATA_W-1:0]                        rd_data
);

    logic [DATA_W-1:0] mem [BANK_WORDS];

    // Whole-block write: all BLK_WORDS words land on the same edge; reset clears the bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BANK_WORDS; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (wr_en) begin
            for (int r = 0; r < BLK_N; r++) begin
                for (int c = 0; c < BLK_N; c++) begin
                    mem[AW'(blk_word_addr(32'(wr_blk), r, c, BLK_N))] <= wr_block[r][c];
                end
            end
        end
    end

    // Registered read; data holds between requests and addresses past the bank keep old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en && (32'(rd_addr) < BANK_WORDS)) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/block_pingpong_buffer.sv
// Collects BLK_N x BLK_N coefficient blocks into two banks handed alternately to the entropy coder.
// Latency: block written on the accept edge; bank_full rises on the closing edge; rd_data one cycle after rd_en.
// Backpressure: in_ready low while the bank being written is FULL; rises the cycle after its release. Macro: TRANSPOSE_EN.
module block_pingpong_buffer
    import prores_buf_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BLK_N        = DEF_BLK_N,
    parameter int DEPTH_BLOCKS = DEF_DEPTH_BLOCKS,
    localparam int BLK_WORDS   = BLK_N * BLK_N,
    localparam int AW          = $clog2(DEPTH_BLOCKS * BLK_WORDS),
    localparam int CW          = $clog2(DEPTH_BLOCKS + 1)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_last,
    input  logic [BLK_N-1:0][BLK_N-1:0][DATA_W-1:0]  in_block,
    output logic [1:0]                               bank_full,
    output logic [1:0][CW-1:0]                       bank_count,
    input  logic                                     rd_en,
    input  logic                                     rd_bank,
    input  logic [AW-1:0]                            rd_addr,
    output logic [DATA_W-1:0]                        rd_data,
    input  logic                                     rd_release
);

    bank_state_t       state [2];
    logic              wr_bank;
    logic [CW-1:0]     blk_cnt;
    logic              rd_sel;
    logic              accept;
    logic              close;
    logic [DATA_W-1:0] bank_rd_data [2];

    // The writer only stalls when its target bank is still owned by the reader.
    assign in_ready = (state[wr_bank] != BANK_FULL);
    assign accept   = in_valid & in_ready;
    assign close    = accept & (in_last | (blk_cnt == CW'(DEPTH_BLOCKS - 1)));

    // Write pointer: block index within the bank, and which bank is being filled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            blk_cnt <= '0;
        end else if (accept) begin
            if (close) begin
                blk_cnt <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    // Per-bank EMPTY -> FILLING -> FULL -> EMPTY machine with registered full flag and count.
    // A bank being written is never FULL and release only acts on FULL banks, so the two
    // branches can never target the same bank in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state[0]   <= BANK_EMPTY;
            state[1]   <= BANK_EMPTY;
            bank_full  <= '0;
            bank_count <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (accept && (wr_bank == 1'(b))) begin
                    if (close) begin
                        state[b]      <= BANK_FULL;
                        bank_full[b]  <= 1'b1;
                        bank_count[b] <= blk_cnt + 1'b1;
                    end else begin
                        state[b]      <= BANK_FILLING;
                    end
                end else if (rd_release && (rd_bank == 1'(b)) && (state[b] == BANK_FULL)) begin
                    state[b]      <= BANK_EMPTY;
                    bank_full[b]  <= 1'b0;
                    bank_count[b] <= '0;
                end
            end
        end
    end

    // Remember which bank the last read came from so the output mux holds with the data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_sel <= 1'b0;
        end else if (rd_en) begin
            rd_sel <= rd_bank;
        end
    end

    assign rd_data = bank_rd_data[rd_sel];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pingpong_bank #(
            .DATA_W       (DATA_W),
            .BLK_N        (BLK_N),
            .DEPTH_BLOCKS (DEPTH_BLOCKS)
        ) u_bank (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (accept && (wr_bank == 1'(g))),
            .wr_blk   (blk_cnt),
            .wr_block (in_block),
            .rd_en    (rd_en && (rd_bank == 1'(g))),
            .rd_addr  (rd_addr),
            .rd_data  (bank_rd_data[g])
        );
    end

endmodule

// File: tb/tb_block_pingpong_buffer.sv
// Directed bench for block_pingpong_buffer at default parameters (32-bit words, 8x8 blocks, 32 blocks per bank).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: writer holds in_valid until in_ready, bounded; expectations follow TRANSPOSE_EN when defined.
module tb_block_pingpong_buffer;

`ifdef TRANSPOSE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic                       in_last = 1'b0;
    logic [7:0][7:0][31:0]      in_block = '0;
    logic [1:0]                 bank_full;
    logic [1:0][5:0]            bank_count;
    logic                       rd_en = 1'b0;
    logic                       rd_bank = 1'b0;
    logic [10:0]                rd_addr = '0;
    logic [31:0]                rd_data;
    logic                       rd_release = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd_val;

    block_pingpong_buffer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_block   (in_block),
        .bank_full  (bank_full),
        .bank_count (bank_count),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_release (rd_release)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load_block(input logic [31:0] base);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                in_block[r][c] = base + 32'(r * 8 + c);
            end
        end
    endtask

    task automatic push(input logic [31:0] base, input logic last);
        int waited;
        waited = 0;
        load_block(base);
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && waited < 64) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rd(input logic bank, input logic [10:0] addr, output logic [31:0] data);
        rd_en   = 1'b1;
        rd_bank = bank;
        rd_addr = addr;
        tick();
        rd_en   = 1'b0;
        data    = rd_data;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_bank_full", 64'(bank_full), 64'd0);
        chk("rst_count0", 64'(bank_count[0]), 64'd0);
        chk("rst_count1", 64'(bank_count[1]), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;
        tick();

        // 1: 32 blocks close bank 0 by depth
        for (int b = 0; b < 32; b++) push(32'(b * 64), 1'b0);
        chk("t1_bank_full", 64'(bank_full), 64'b01);
        chk("t1_count0", 64'(bank_count[0]), 64'd32);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        rd(1'b0, 11'd71, rd_val);
        chk("t1_rd71", 64'(rd_val), TR ? 64'd120 : 64'd71);
        rd(1'b0, 11'd2047, rd_val);
        chk("t1_rd2047", 64'(rd_val), 64'd2047);

        // 2: early close with in_last, next block goes to bank 1 block 0
        do_reset();
        push(32'h1000, 1'b0);
        push(32'h2000, 1'b0);
        push(32'h3000, 1'b1);
        chk("t2_bank_full", 64'(bank_full), 64'b01);
        chk("t2_count0", 64'(bank_count[0]), 64'd3);
        push(32'h7000, 1'b0);
        chk("t2_bank_full_b", 64'(bank_full), 64'b01);
        rd(1'b1, 11'd9, rd_val);
        chk("t2_b1_rd9", 64'(rd_val), 64'h7009);
        rd(1'b0, 11'd130, rd_val);
        chk("t2_b0_rd130", 64'(rd_val), TR ? 64'h3010 : 64'h3002);

        // 3: both banks full, writer stalls, release bank 0
        push(32'h8000, 1'b1);
        chk("t3_bank_full", 64'(bank_full), 64'b11);
        chk("t3_count1", 64'(bank_count[1]), 64'd2);
        chk("t3_stall", 64'(in_ready), 64'd0);
        load_block(32'hA000);
        in_valid = 1'b1;
        tick();
        chk("t3_stall_held", 64'(in_ready), 64'd0);
        rd_release = 1'b1;
        rd_bank    = 1'b0;
        #2;
        chk("t3_no_bypass", 64'(in_ready), 64'd0);
        tick();
        rd_release = 1'b0;
        chk("t3_ready_after", 64'(in_ready), 64'd1);
        chk("t3_full_after_rel", 64'(bank_full), 64'b10);
        chk("t3_count0_rel", 64'(bank_count[0]), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("t3_full_filling", 64'(bank_full), 64'b10);
        rd(1'b0, 11'd0, rd_val);
        chk("t3_held_block", 64'(rd_val), 64'hA000);
        rd(1'b0, 11'd64, rd_val);
        chk("t3_old_contents", 64'(rd_val), 64'h2000);

        // 4: read and release bank 1 in the same cycle
        rd_en      = 1'b1;
        rd_bank    = 1'b1;
        rd_addr    = 11'd69;
        rd_release = 1'b1;
        tick();
        rd_en      = 1'b0;
        rd_release = 1'b0;
        chk("t4_rd_with_rel", 64'(rd_data), TR ? 64'h8028 : 64'h8005);
        chk("t4_full", 64'(bank_full), 64'b00);
        chk("t4_count1", 64'(bank_count[1]), 64'd0);
        tick();
        chk("t4_rd_hold", 64'(rd_data), TR ? 64'h8028 : 64'h8005);
        rd_release = 1'b1;
        rd_bank    = 1'b0;
        tick();
        rd_release = 1'b0;
        chk("t4_rel_filling", 64'(bank_full), 64'b00);
        chk("t4_ready", 64'(in_ready), 64'd1);
        push(32'hB000, 1'b1);
        chk("t4_close_full", 64'(bank_full), 64'b01);
        chk("t4_close_count", 64'(bank_count[0]), 64'd2);
        rd_release = 1'b1;
        rd_bank    = 1'b1;
        tick();
        rd_release = 1'b0;
        chk("t4_rel_empty", 64'(bank_full), 64'b01);
        chk("t4_rel_empty_cnt", 64'(bank_count[0]), 64'd2);
        rd(1'b1, 11'd69, rd_val);
        chk("t4_not_cleared", 64'(rd_val), TR ? 64'h8028 : 64'h8005);

        // 5: asynchronous reset mid-fill
        do_reset();
        for (int b = 0; b < 5; b++) push(32'h4000 + 32'(b * 256), 1'b0);
        rd(1'b0, 11'd65, rd_val);
        chk("t5_pre_rd", 64'(rd_val), TR ? 64'h4108 : 64'h4101);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_async_full", 64'(bank_full), 64'd0);
        chk("t5_async_count", 64'(bank_count[0]), 64'd0);
        chk("t5_async_rd", 64'(rd_data), 64'd0);
        chk("t5_async_ready", 64'(in_ready), 64'd1);
        #2;
        reset = 1'b0;
        tick();
        push(32'h5500, 1'b1);
        chk("t5_full", 64'(bank_full), 64'b01);
        chk("t5_count", 64'(bank_count[0]), 64'd1);
        rd(1'b0, 11'd0, rd_val);
        chk("t5_blk0", 64'(rd_val), 64'h5500);
        rd(1'b0, 11'd64, rd_val);
        chk("t5_cleared", 64'(rd_val), 64'd0);

        // 6: layout of a single block
        do_reset();
        push(32'd0, 1'b1);
        rd(1'b0, 11'd1, rd_val);
        chk("t6_addr1", 64'(rd_val), TR ? 64'd8 : 64'd1);
        rd(1'b0, 11'd8, rd_val);
        chk("t6_addr8", 64'(rd_val), TR ? 64'd1 : 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
